// File: rtl/result_bcd_display_if.sv
// Bundle between the result selector / board and the BCD display driver.
// value/is_signed flow in; segments, status and a debug view of the FSM state flow out.
interface result_bcd_display_if;
  logic [31:0] value;
  logic        is_signed;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;
  logic [6:0]  HEX4;
  logic [6:0]  HEX5;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [1:0]  dbg_state;

  modport master (
    output value, is_signed,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, done, ovf, dbg_state
  );

  modport slave (
    input  value, is_signed,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, done, ovf, dbg_state
  );
endinterface

// File: rtl/result_bcd_display.sv
// Iterative 32-bit binary to 6-digit BCD converter (shift-add-3, one bit per clock)
// driving active-low seven-segment digits, with sign digit and overflow dashes.
module result_bcd_display (
  input  logic                  clk,
  input  logic                  reset,
  result_bcd_display_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_UPDATE = 2'd2} state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_last_value;
  logic        r_last_signed;
  logic        r_pend;
  logic [31:0] r_mag;
  logic [39:0] r_bcd;
  logic        r_neg;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_ovf;
  logic [6:0]  r_hex [6];

  logic        w_start;
  logic        w_neg_in;
  logic [31:0] w_mag_in;
  logic [39:0] w_bcd_adj;
  logic        w_ovf;
  logic        w_seen;
  logic [3:0]  w_dig;
  logic [6:0]  w_seg [6];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign w_start  = r_pend || (bus.value != r_last_value) || (bus.is_signed != r_last_signed);
  assign w_neg_in = bus.is_signed && bus.value[31];
  // Two's complement negation in 32 bits: 0x80000000 maps to itself, i.e. 2^31 unsigned.
  assign w_mag_in = w_neg_in ? (~bus.value + 32'd1) : bus.value;
  assign w_ovf    = r_last_signed ? (r_bcd[39:20] != 20'd0) : (r_bcd[39:24] != 16'd0);

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 10; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking scans from the top digit; HEX0 always shows a digit.
  always_comb begin
    w_seen = 1'b0;
    w_dig  = 4'd0;
    for (int i = 0; i < 6; i++) w_seg[i] = SEG_BLANK;
    for (int i = 5; i >= 0; i--) begin
      w_dig = r_bcd[i*4 +: 4];
      if (i == 5 && r_last_signed) begin
        w_seg[i] = r_neg ? SEG_DASH : SEG_BLANK;
      end else begin
        if (w_dig != 4'd0) w_seen = 1'b1;
        w_seg[i] = (w_seen || i == 0) ? seg7(w_dig) : SEG_BLANK;
      end
    end
    if (w_ovf) begin
      for (int i = 0; i < 6; i++) w_seg[i] = SEG_DASH;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next_state = S_SHIFT;
      S_SHIFT:  if (r_cnt == 5'd31) w_next_state = S_UPDATE;
      S_UPDATE: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_last_value  <= 32'd0;
      r_last_signed <= 1'b0;
      r_pend        <= 1'b1;
      r_mag         <= 32'd0;
      r_bcd         <= 40'd0;
      r_neg         <= 1'b0;
      r_cnt         <= 5'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ovf         <= 1'b0;
      for (int i = 0; i < 6; i++) r_hex[i] <= SEG_BLANK;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_last_value  <= bus.value;
            r_last_signed <= bus.is_signed;
            r_pend        <= 1'b0;
            r_mag         <= w_mag_in;
            r_neg         <= w_neg_in;
            r_bcd         <= 40'd0;
            r_cnt         <= 5'd0;
            r_busy        <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_bcd_adj[38:0], r_mag[31]};
          r_mag <= {r_mag[30:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        S_UPDATE: begin
          for (int i = 0; i < 6; i++) r_hex[i] <= w_seg[i];
          r_ovf  <= w_ovf;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.HEX0      = r_hex[0];
  assign bus.HEX1      = r_hex[1];
  assign bus.HEX2      = r_hex[2];
  assign bus.HEX3      = r_hex[3];
  assign bus.HEX4      = r_hex[4];
  assign bus.HEX5      = r_hex[5];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: conversions, sign/overflow formatting,
// latency, mid-conversion input change and mid-conversion reset.
module tb_result_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n;

  result_bcd_display_if bus ();

  result_bcd_display dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      tick();
      cnt++;
      if (bus.done === 1'b1) break;
    end
    chk({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_busy_low_at_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic chk_disp(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                          input logic [6:0] e3, input logic [6:0] e2, input logic [6:0] e1,
                          input logic [6:0] e0, input logic eovf);
    chk({tag, "_HEX5"}, {25'd0, bus.HEX5}, {25'd0, e5});
    chk({tag, "_HEX4"}, {25'd0, bus.HEX4}, {25'd0, e4});
    chk({tag, "_HEX3"}, {25'd0, bus.HEX3}, {25'd0, e3});
    chk({tag, "_HEX2"}, {25'd0, bus.HEX2}, {25'd0, e2});
    chk({tag, "_HEX1"}, {25'd0, bus.HEX1}, {25'd0, e1});
    chk({tag, "_HEX0"}, {25'd0, bus.HEX0}, {25'd0, e0});
    chk({tag, "_ovf"},  {31'd0, bus.ovf},  {31'd0, eovf});
  endtask

  task automatic convert(input string tag, input logic [31:0] v, input logic s);
    int c;
    bus.value     = v;
    bus.is_signed = s;
    wait_done(tag, 100, c);
    chk({tag, "_latency"}, c, 32'd34);
  endtask

  task automatic chk_reset_state(input string tag);
    chk_disp(tag, SB, SB, SB, SB, SB, SB, 1'b0);
    chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, bus.done}, 32'd0);
    chk({tag, "_state"}, {30'd0, bus.dbg_state}, 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.value     = 32'd0;
    bus.is_signed = 1'b1;
    repeat (3) tick();
    chk_reset_state("rst");

    // release reset: pend forces conversion of 0; E0 is the first edge with reset high
    reset = 1'b1;
    tick();
    n = 1;
    chk("busy_after_E0", {31'd0, bus.busy}, 32'd1);
    chk("no_done_after_E0", {31'd0, bus.done}, 32'd0);
    while (n < 60 && bus.done !== 1'b1) begin
      tick();
      n++;
      if (bus.done !== 1'b1) chk("hex0_stable_during_conv", {25'd0, bus.HEX0}, {25'd0, SB});
    end
    chk("first_done_edges", n, 32'd34);
    chk_disp("zero", SB, SB, SB, SB, SB, S0, 1'b0);
    tick();
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);

    convert("v305", 32'd305, 1'b1);
    chk_disp("v305", SB, SB, SB, S3, S0, S5, 1'b0);

    convert("neg7", 32'hFFFF_FFF9, 1'b1);
    chk_disp("neg7", SD, SB, SB, SB, SB, S7, 1'b0);

    convert("neg7_unsigned", 32'hFFFF_FFF9, 1'b0);
    chk_disp("neg7_unsigned", SD, SD, SD, SD, SD, SD, 1'b1);

    convert("u123456", 32'd123456, 1'b0);
    chk_disp("u123456", S1, S2, S3, S4, S5, S6, 1'b0);

    convert("s123456", 32'd123456, 1'b1);
    chk_disp("s123456", SD, SD, SD, SD, SD, SD, 1'b1);

    convert("min_neg", 32'h8000_0000, 1'b1);
    chk_disp("min_neg", SD, SD, SD, SD, SD, SD, 1'b1);

    convert("s99999", 32'd99999, 1'b1);
    chk_disp("s99999", SB, S9, S9, S9, S9, S9, 1'b0);

    convert("u999999", 32'd999999, 1'b0);
    chk_disp("u999999", S9, S9, S9, S9, S9, S9, 1'b0);

    convert("u1000000", 32'd1000000, 1'b0);
    chk_disp("u1000000", SD, SD, SD, SD, SD, SD, 1'b1);

    // input change at SHIFT cycle 10 is ignored until the next IDLE compare
    bus.value     = 32'd11;
    bus.is_signed = 1'b1;
    repeat (11) tick();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    bus.value = 32'd22;
    wait_done("mid_first", 60, n);
    chk("mid_first_latency", n, 32'd23);
    chk_disp("mid_first", SB, SB, SB, SB, S1, S1, 1'b0);
    wait_done("mid_second", 60, n);
    chk("mid_second_latency", n, 32'd34);
    chk_disp("mid_second", SB, SB, SB, SB, S2, S2, 1'b0);

    // reset at SHIFT cycle 15 aborts and blanks immediately
    bus.value = 32'd33;
    repeat (16) tick();
    chk("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    tick();
    chk_reset_state("abort");
    reset = 1'b1;
    wait_done("after_abort", 60, n);
    chk("after_abort_latency", n, 32'd34);
    chk_disp("after_abort", SB, SB, SB, SB, S3, S3, 1'b0);

    // nothing changes while inputs are stable
    repeat (5) tick();
    chk("idle_stable_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_stable_state", {30'd0, bus.dbg_state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
